regfile_wb_arbiter: RTL and testbench

//  Shares the regfile's single synchronous write port between two writeback

---
 rtl/regfile_wb_arbiter.sv | 220 ++++++++++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Two-requester writeback arbiter onto the single regfile write port.
// Accept-to-RegWrite latency 1 cycle uncontended; per-side Ready drops on full FIFO or cross-side same-register hazard.

// Generic FIFO with per-slot valid bits, exposing every entry for hazard lookup.
// Latency: push visible at head the cycle after the edge; no pass-through.
// Backpressure: caller must not push when full; pop only when non-empty.
module regfile_wb_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 37
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push_vld,
    input  logic [W-1:0]              push_dat,
    input  logic                      pop,
    output logic                      full,
    output logic                      empty,
    output logic [W-1:0]              head_dat,
    output logic [DEPTH-1:0]          ent_vld,
    output logic [DEPTH-1:0][W-1:0]   ent_dat
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
    logic [DEPTH-1:0]        vld_q, vld_d;
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]           rd_ptr_q, rd_ptr_d;

    // Push and pop never target the same slot: push needs a free slot, pop a valid one.
    always_comb begin
        mem_d    = mem_q;
        vld_d    = vld_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_vld) begin
            mem_d[wr_ptr_q] = push_dat;
            vld_d[wr_ptr_q] = 1'b1;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d        = rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '0;
            vld_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            mem_q    <= mem_d;
            vld_q    <= vld_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    assign full     = &vld_q;
    assign empty    = ~|vld_q;
    assign head_dat = mem_q[rd_ptr_q];
    assign ent_vld  = vld_q;
    assign ent_dat  = mem_q;
endmodule

// Round-robin drain of the A (ALU) and B (load) writeback FIFOs into registered port outputs.
// Latency: accept at edge k -> RegWrite high k+1..k+2. Backpressure: X_Ready = !full && !hazard.
module regfile_wb_arbiter #(
    parameter int DEPTH = 2,
    parameter int DW    = 32,
    parameter int AW    = 5
) (
    input  logic          Clk,
    input  logic          Rst_n,
    input  logic          A_Valid,
    output logic          A_Ready,
    input  logic [AW-1:0] A_Reg,
    input  logic [DW-1:0] A_Data,
    input  logic          B_Valid,
    output logic          B_Ready,
    input  logic [AW-1:0] B_Reg,
    input  logic [DW-1:0] B_Data,
    output logic          RegWrite,
    output logic [AW-1:0] WriteRegister,
    output logic [DW-1:0] WriteData,
    output logic [31:0]   Pending,
    output logic          Busy
);
    typedef struct packed {
        logic [AW-1:0] rd;
        logic [DW-1:0] dat;
    } wb_t;

    localparam int EW = AW + DW;

    typedef enum logic {
        LAST_A = 1'b0,
        LAST_B = 1'b1
    } rr_e;

    wb_t                      a_in, b_in, a_head, b_head;
    logic                     a_full, a_empty, b_full, b_empty;
    logic [DEPTH-1:0]         a_ent_vld, b_ent_vld;
    logic [DEPTH-1:0][EW-1:0] a_ent, b_ent;
    logic                     a_hit, b_hit;
    logic                     a_zero, b_zero;
    logic                     a_rdy, b_rdy;
    logic                     a_push, b_push;
    logic                     gnt_a, gnt_b;

    rr_e                      rr_q, rr_d;
    logic                     reg_write_q, reg_write_d;
    logic [AW-1:0]            wr_reg_q, wr_reg_d;
    logic [DW-1:0]            wr_dat_q, wr_dat_d;

    assign a_in = '{rd: A_Reg, dat: A_Data};
    assign b_in = '{rd: B_Reg, dat: B_Data};

    regfile_wb_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo_a (
        .clk      (Clk),
        .rst_n    (Rst_n),
        .push_vld (a_push),
        .push_dat (a_in),
        .pop      (gnt_a),
        .full     (a_full),
        .empty    (a_empty),
        .head_dat (a_head),
        .ent_vld  (a_ent_vld),
        .ent_dat  (a_ent)
    );

    regfile_wb_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo_b (
        .clk      (Clk),
        .rst_n    (Rst_n),
        .push_vld (b_push),
        .push_dat (b_in),
        .pop      (gnt_b),
        .full     (b_full),
        .empty    (b_empty),
        .head_dat (b_head),
        .ent_vld  (b_ent_vld),
        .ent_dat  (b_ent)
    );

    // A request stalls behind any queued B write to the same register, and vice versa.
    always_comb begin
        a_hit = 1'b0;
        b_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (b_ent_vld[i] && (b_ent[i][EW-1 -: AW] == A_Reg)) a_hit = 1'b1;
            if (a_ent_vld[i] && (a_ent[i][EW-1 -: AW] == B_Reg)) b_hit = 1'b1;
        end
    end

    assign a_zero = (A_Reg == '0);
    assign b_zero = (B_Reg == '0);

    // Simultaneous same-register requests resolve in A's favour.
    assign a_rdy = Rst_n && !a_full && (a_zero || !a_hit);
    assign b_rdy = Rst_n && !b_full &&
                   (b_zero || !(b_hit || (A_Valid && a_rdy && (A_Reg == B_Reg))));

    assign a_push = A_Valid && a_rdy && !a_zero;
    assign b_push = B_Valid && b_rdy && !b_zero;

    assign A_Ready = a_rdy;
    assign B_Ready = b_rdy;

    assign gnt_a = !a_empty && (b_empty || (rr_q == LAST_B));
    assign gnt_b = !b_empty && !gnt_a;

    always_comb begin
        rr_d        = rr_q;
        reg_write_d = gnt_a || gnt_b;
        wr_reg_d    = wr_reg_q;
        wr_dat_d    = wr_dat_q;
        if (gnt_a) begin
            rr_d     = LAST_A;
            wr_reg_d = a_head.rd;
            wr_dat_d = a_head.dat;
        end else if (gnt_b) begin
            rr_d     = LAST_B;
            wr_reg_d = b_head.rd;
            wr_dat_d = b_head.dat;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rr_q        <= LAST_B;
            reg_write_q <= 1'b0;
            wr_reg_q    <= '0;
            wr_dat_q    <= '0;
        end else begin
            rr_q        <= rr_d;
            reg_write_q <= reg_write_d;
            wr_reg_q    <= wr_reg_d;
            wr_dat_q    <= wr_dat_d;
        end
    end

    assign RegWrite      = reg_write_q;
    assign WriteRegister = wr_reg_q;
    assign WriteData     = wr_dat_q;

    // Register 0 never enters a FIFO, so starting at 1 keeps Pending[0] low.
    always_comb begin
        Pending = '0;
        for (int r = 1; r < 32; r++) begin
            if (reg_write_q && (wr_reg_q == AW'(r))) Pending[r] = 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                if (a_ent_vld[i] && (a_ent[i][EW-1 -: AW] == AW'(r))) Pending[r] = 1'b1;
                if (b_ent_vld[i] && (b_ent[i][EW-1 -: AW] == AW'(r))) Pending[r] = 1'b1;
            end
        end
    end

    assign Busy = !a_empty || !b_empty || reg_write_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed vector table plus streaming and reset sequences for regfile_wb_arbiter.
module tb_regfile_wb_arbiter;
    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        A_Valid, B_Valid, A_Ready, B_Ready;
    logic [4:0]  A_Reg, B_Reg, WriteRegister;
    logic [31:0] A_Data, B_Data, WriteData, Pending;
    logic        RegWrite, Busy;

    always #5 Clk = ~Clk;

    regfile_wb_arbiter #(.DEPTH(2), .DW(32), .AW(5)) dut (
        .Clk           (Clk),
        .Rst_n         (Rst_n),
        .A_Valid       (A_Valid),
        .A_Ready       (A_Ready),
        .A_Reg         (A_Reg),
        .A_Data        (A_Data),
        .B_Valid       (B_Valid),
        .B_Ready       (B_Ready),
        .B_Reg         (B_Reg),
        .B_Data        (B_Data),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .Pending       (Pending),
        .Busy          (Busy)
    );

    typedef struct {
        logic        av;
        logic [4:0]  ar;
        logic [31:0] ad;
        logic        bv;
        logic [4:0]  br;
        logic [31:0] bd;
        logic        ea;
        logic        eb;
        logic        erw;
        logic [4:0]  ewr;
        logic [31:0] ewd;
        logic [31:0] ep;
        logic        ebusy;
    } vec_t;

    vec_t        vq[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    bit          mon_en  = 1'b0;
    logic [36:0] obs[$];
    logic [4:0]  ra[20], rb[20];
    logic [31:0] da[20], db[20];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                       input logic bv, input logic [4:0] br, input logic [31:0] bd,
                       input logic ea, input logic eb, input logic erw, input logic [4:0] ewr,
                       input logic [31:0] ewd, input logic [31:0] ep, input logic ebusy);
        vec_t v;
        v = '{av, ar, ad, bv, br, bd, ea, eb, erw, ewr, ewd, ep, ebusy};
        vq.push_back(v);
    endtask

    task automatic set_idle();
        A_Valid = 1'b0; A_Reg = '0; A_Data = '0;
        B_Valid = 1'b0; B_Reg = '0; B_Data = '0;
    endtask

    always @(negedge Clk) begin
        if (mon_en && RegWrite) obs.push_back({WriteRegister, WriteData});
    end

    task automatic drive_a(output int stalls, output bit timeout);
        stalls = 0; timeout = 1'b0;
        for (int i = 0; i < 20; i++) begin
            bit fired;
            int guard;
            fired = 1'b0; guard = 0;
            @(posedge Clk); #1;
            A_Valid = 1'b1; A_Reg = ra[i]; A_Data = da[i];
            while (!fired && guard < 100) begin
                @(negedge Clk);
                if (A_Ready) fired = 1'b1;
                else begin stalls++; @(posedge Clk); #1; end
                guard++;
            end
            if (!fired) timeout = 1'b1;
        end
        @(posedge Clk); #1;
        A_Valid = 1'b0; A_Reg = '0;
    endtask

    task automatic drive_b(output int stalls, output bit timeout);
        stalls = 0; timeout = 1'b0;
        for (int i = 0; i < 20; i++) begin
            bit fired;
            int guard;
            fired = 1'b0; guard = 0;
            @(posedge Clk); #1;
            B_Valid = 1'b1; B_Reg = rb[i]; B_Data = db[i];
            while (!fired && guard < 100) begin
                @(negedge Clk);
                if (B_Ready) fired = 1'b1;
                else begin stalls++; @(posedge Clk); #1; end
                guard++;
            end
            if (!fired) timeout = 1'b1;
        end
        @(posedge Clk); #1;
        B_Valid = 1'b0; B_Reg = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   sa, sb, ia, ib, g, rw_seen;
        bit   ta, tb;
        vec_t v;

        //    av rA  dA           bv rB  dB    | rdyA rdyB rw wr  wd           pending      busy
        add(1, 5, 32'hDEADBEEF, 0, 0, 0,     1, 1, 0, 0,  32'h0,        32'h0,       0); // 0
        add(0, 0, 0,            0, 0, 0,     1, 1, 0, 0,  32'h0,        32'h20,      1); // 1
        add(0, 0, 0,            0, 0, 0,     1, 1, 1, 5,  32'hDEADBEEF, 32'h20,      1); // 2
        add(0, 0, 0,            0, 0, 0,     1, 1, 0, 5,  32'hDEADBEEF, 32'h0,       0); // 3
        add(0, 0, 0,            1, 6, 'h66,  1, 1, 0, 5,  32'hDEADBEEF, 32'h0,       0); // 4
        add(0, 0, 0,            0, 0, 0,     1, 1, 0, 5,  32'hDEADBEEF, 32'h40,      1); // 5
        add(1, 3, 1,            1, 4, 2,     1, 1, 1, 6,  32'h66,       32'h40,      1); // 6
        add(0, 0, 0,            0, 0, 0,     1, 1, 0, 6,  32'h66,       32'h18,      1); // 7
        add(0, 0, 0,            0, 0, 0,     1, 1, 1, 3,  32'h1,        32'h18,      1); // 8
        add(1, 10, 'hA0,        0, 0, 0,     1, 1, 1, 4,  32'h2,        32'h10,      1); // 9
        add(1, 8, 'h80,         1, 9, 'h90,  1, 1, 0, 4,  32'h2,        32'h400,     1); // 10
        add(0, 0, 0,            0, 0, 0,     1, 1, 1, 10, 32'hA0,       32'h700,     1); // 11
        add(0, 0, 0,            0, 0, 0,     1, 1, 1, 9,  32'h90,       32'h300,     1); // 12
        add(0, 0, 0,            0, 0, 0,     1, 1, 1, 8,  32'h80,       32'h100,     1); // 13
        add(1, 7, 'h11,         1, 7, 'h22,  1, 0, 0, 8,  32'h80,       32'h0,       0); // 14
        add(0, 0, 0,            1, 7, 'h22,  1, 0, 0, 8,  32'h80,       32'h80,      1); // 15
        add(0, 0, 0,            1, 7, 'h22,  1, 1, 1, 7,  32'h11,       32'h80,      1); // 16
        add(0, 0, 0,            0, 0, 0,     1, 1, 0, 7,  32'h11,       32'h80,      1); // 17
        add(0, 0, 0,            0, 0, 0,     1, 1, 1, 7,  32'h22,       32'h80,      1); // 18
        add(1, 0, 'hFFFF,       0, 0, 0,     1, 1, 0, 7,  32'h22,       32'h0,       0); // 19
        add(0, 0, 0,            1, 12, 'hC0, 1, 1, 0, 7,  32'h22,       32'h0,       0); // 20
        add(1, 12, 'hC1,        0, 0, 0,     0, 1, 0, 7,  32'h22,       32'h1000,    1); // 21
        add(1, 12, 'hC1,        0, 0, 0,     1, 1, 1, 12, 32'hC0,       32'h1000,    1); // 22
        add(0, 0, 0,            0, 0, 0,     1, 1, 0, 12, 32'hC0,       32'h1000,    1); // 23
        add(0, 0, 0,            0, 0, 0,     1, 1, 1, 12, 32'hC1,       32'h1000,    1); // 24
        add(0, 0, 0,            0, 0, 0,     1, 1, 0, 12, 32'hC1,       32'h0,       0); // 25

        set_idle();
        Rst_n = 1'b0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check("rst_rdy_a_low", A_Ready, 0);
        check("rst_rdy_b_low", B_Ready, 0);
        @(posedge Clk); #3;
        Rst_n = 1'b1;
        @(negedge Clk);
        check("rst_rdy_a", A_Ready, 1);
        check("rst_rdy_b", B_Ready, 1);
        check("rst_regwrite", RegWrite, 0);
        check("rst_wreg", WriteRegister, 0);
        check("rst_wdata", WriteData, 0);
        check("rst_pending", Pending, 0);
        check("rst_busy", Busy, 0);

        foreach (vq[i]) begin
            v = vq[i];
            @(posedge Clk); #1;
            A_Valid = v.av; A_Reg = v.ar; A_Data = v.ad;
            B_Valid = v.bv; B_Reg = v.br; B_Data = v.bd;
            @(negedge Clk);
            check($sformatf("row%0d rdy_a", i), A_Ready, v.ea);
            check($sformatf("row%0d rdy_b", i), B_Ready, v.eb);
            check($sformatf("row%0d regwrite", i), RegWrite, v.erw);
            check($sformatf("row%0d wreg", i), WriteRegister, v.ewr);
            check($sformatf("row%0d wdata", i), WriteData, v.ewd);
            check($sformatf("row%0d pending", i), Pending, v.ep);
            check($sformatf("row%0d busy", i), Busy, v.ebusy);
        end
        @(posedge Clk); #1;
        set_idle();

        for (int i = 0; i < 20; i++) begin
            ra[i] = 5'($urandom_range(15, 1));
            rb[i] = 5'($urandom_range(31, 16));
            da[i] = $urandom;
            db[i] = $urandom;
        end
        mon_en = 1'b1;
        fork
            drive_a(sa, ta);
            drive_b(sb, tb);
        join
        g = 0;
        while (Busy && g < 200) begin @(negedge Clk); g++; end
        @(negedge Clk);
        mon_en = 1'b0;
        check("stream_timeout_a", ta, 0);
        check("stream_timeout_b", tb, 0);
        check("stream_drain_timeout", g < 200, 1);
        check("stream_a_stalled_when_full", sa > 0, 1);
        check("stream_b_stalled_when_full", sb > 0, 1);
        check("stream_write_count", obs.size(), 40);
        ia = 0; ib = 0;
        foreach (obs[k]) begin
            if (obs[k][36:32] < 5'd16) begin
                if (ia < 20) check($sformatf("stream_a%0d", ia), obs[k], {ra[ia], da[ia]});
                ia++;
            end else begin
                if (ib < 20) check($sformatf("stream_b%0d", ib), obs[k], {rb[ib], db[ib]});
                ib++;
            end
        end
        check("stream_a_count", ia, 20);
        check("stream_b_count", ib, 20);

        @(posedge Clk); #1;
        A_Valid = 1'b1; A_Reg = 5'd13; A_Data = 32'hD13;
        B_Valid = 1'b1; B_Reg = 5'd14; B_Data = 32'hE14;
        @(posedge Clk); #1;
        set_idle();
        @(posedge Clk); #3;
        check("midrst_pre_regwrite", RegWrite, 1);
        check("midrst_pre_busy", Busy, 1);
        Rst_n = 1'b0;
        #1;
        check("midrst_regwrite", RegWrite, 0);
        check("midrst_rdy_a", A_Ready, 0);
        check("midrst_rdy_b", B_Ready, 0);
        check("midrst_pending", Pending, 0);
        check("midrst_busy", Busy, 0);
        check("midrst_wreg", WriteRegister, 0);
        check("midrst_wdata", WriteData, 0);
        @(negedge Clk);
        @(posedge Clk); #3;
        Rst_n = 1'b1;
        rw_seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge Clk);
            if (RegWrite) rw_seen++;
        end
        check("postrst_no_writes", rw_seen, 0);
        check("postrst_busy", Busy, 0);
        check("postrst_pending", Pending, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
